// File: rtl/l2_instruction_responder.sv
// L2-side instruction fetch responder: one outstanding word read from a
// write-loadable instruction memory, returned after a fixed latency.
module l2_instruction_responder #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int L2_BUS_WIDTH   = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 2
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    output logic                      ADDRESS_TO_L2_READY_INS,
    input  logic                      ADDRESS_TO_L2_VALID_INS,
    input  logic [ADDRESS_WIDTH-3:0]  ADDRESS_TO_L2_INS,
    input  logic                      DATA_FROM_L2_READY_INS,
    output logic                      DATA_FROM_L2_VALID_INS,
    output logic [L2_BUS_WIDTH-1:0]   DATA_FROM_L2_INS,
    input  logic                      MEM_WR_EN,
    input  logic [MEM_DEPTH_LOG2-1:0] MEM_WR_ADDR,
    input  logic [L2_BUS_WIDTH-1:0]   MEM_WR_DATA
);

    localparam int CW = $clog2(READ_LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                      valid_q, valid_d;
    logic [L2_BUS_WIDTH-1:0]   data_q, data_d;

    logic [L2_BUS_WIDTH-1:0] mem [2**MEM_DEPTH_LOG2];

    // Word address wraps modulo memory depth; upper bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits =
        ^ADDRESS_TO_L2_INS[ADDRESS_WIDTH-3:MEM_DEPTH_LOG2];

    always_ff @(posedge CLK) begin
        if (MEM_WR_EN) begin
            mem[MEM_WR_ADDR] <= MEM_WR_DATA;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (ADDRESS_TO_L2_VALID_INS) begin
                    idx_d   = ADDRESS_TO_L2_INS[MEM_DEPTH_LOG2-1:0];
                    cnt_d   = CW'(READ_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    data_d  = mem[idx_q];
                    valid_d = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (DATA_FROM_L2_READY_INS) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ADDRESS_TO_L2_READY_INS = RST_N & (state_q == IDLE);
    assign DATA_FROM_L2_VALID_INS  = valid_q;
    assign DATA_FROM_L2_INS        = data_q;

endmodule

// File: tb/tb_l2_instruction_responder.sv
// Self-checking bench for l2_instruction_responder: vector table plus
// hand-written latency, stall, reset and write-collision sequences.
module tb_l2_instruction_responder;

    logic        clk;
    logic        rst_n;
    logic        a_rdy;
    logic        a_vld;
    logic [29:0] a_addr;
    logic        d_rdy;
    logic        d_vld;
    logic [31:0] d_data;
    logic        we;
    logic [9:0]  wa;
    logic [31:0] wd;

    int tests;
    int fails;

    logic [31:0] sb[$];

    typedef struct {
        logic [29:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    l2_instruction_responder dut (
        .CLK                     (clk),
        .RST_N                   (rst_n),
        .ADDRESS_TO_L2_READY_INS (a_rdy),
        .ADDRESS_TO_L2_VALID_INS (a_vld),
        .ADDRESS_TO_L2_INS       (a_addr),
        .DATA_FROM_L2_READY_INS  (d_rdy),
        .DATA_FROM_L2_VALID_INS  (d_vld),
        .DATA_FROM_L2_INS        (d_data),
        .MEM_WR_EN               (we),
        .MEM_WR_ADDR             (wa),
        .MEM_WR_DATA             (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, so negedge sees
    // exactly the values the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n && d_vld && d_rdy) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got %h expected none", d_data);
            end else begin
                check("sb_data", d_data, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] idx, input logic [31:0] data);
        we = 1'b1;
        wa = idx;
        wd = data;
        tick();
        we = 1'b0;
    endtask

    task automatic req_accept(input logic [29:0] addr, input logic [31:0] exp);
        int n;
        sb.push_back(exp);
        a_vld  = 1'b1;
        a_addr = addr;
        n = 0;
        while (!a_rdy && n < 20) begin
            tick();
            n++;
        end
        if (!a_rdy) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got ready=0 expected 1");
        end
        tick();
        a_vld = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        a_vld  = 1'b0;
        a_addr = '0;
        d_rdy  = 1'b0;
        we     = 1'b0;
        wa     = '0;
        wd     = '0;

        vecs[0] = '{30'h1,        32'd16};
        vecs[1] = '{30'h2,        32'd32};
        vecs[2] = '{30'h3,        32'd48};
        vecs[3] = '{30'h400,      32'h13};
        vecs[4] = '{30'h3FFFFFFF, 32'hCAFEF00D};

        #12;
        check("rst_ready", a_rdy, 0);
        check("rst_valid", d_vld, 0);
        check("rst_data", d_data, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", a_rdy, 1);

        wr(10'd5, 32'hDEADBEEF);
        wr(10'd1, 32'd16);
        wr(10'd2, 32'd32);
        wr(10'd3, 32'd48);
        wr(10'd0, 32'h13);
        wr(10'd1023, 32'hCAFEF00D);
        wr(10'd7, 32'h77);
        wr(10'd9, 32'h99);
        wr(10'd8, 32'h100);
        wr(10'd10, 32'hA);

        // Exact latency on a single fetch
        d_rdy = 1'b1;
        sb.push_back(32'hDEADBEEF);
        a_addr = 30'h5;
        a_vld  = 1'b1;
        check("t1_ready_idle", a_rdy, 1);
        tick();
        a_vld = 1'b0;
        check("t1_valid_e0", d_vld, 0);
        check("t1_ready_wait", a_rdy, 0);
        tick();
        check("t1_valid_e1", d_vld, 0);
        tick();
        check("t1_valid_e2", d_vld, 1);
        check("t1_data", d_data, 32'hDEADBEEF);
        tick();
        check("t1_valid_done", d_vld, 0);
        check("t1_ready_back", a_rdy, 1);

        // Vector table: back-to-back requests incl. wrap-around addresses
        for (int i = 0; i < 5; i++) begin
            req_accept(vecs[i].addr, vecs[i].exp);
            a_vld  = 1'b1;
            check("tab_ready_busy", a_rdy, 0);
        end
        a_vld = 1'b0;
        wait_empty("tab_drain");

        // Consumer stall while in RESPOND
        d_rdy = 1'b0;
        req_accept(30'h2, 32'd32);
        a_vld  = 1'b1;
        a_addr = 30'h3;
        for (int i = 0; i < 10 && !d_vld; i++) tick();
        for (int k = 0; k < 5; k++) begin
            check("t3_valid_hold", d_vld, 1);
            check("t3_data_hold", d_data, 32'd32);
            check("t3_no_accept", a_rdy, 0);
            tick();
        end
        d_rdy = 1'b1;
        tick();
        check("t3_valid_done", d_vld, 0);
        check("t3_sb_popped", sb.size(), 0);
        sb.push_back(32'd48);
        tick();
        a_vld = 1'b0;
        wait_empty("t3_drain");

        // Reset while waiting drops the request
        a_addr = 30'h9;
        a_vld  = 1'b1;
        tick();
        a_vld = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_ready_rst", a_rdy, 0);
        check("t5_valid_rst", d_vld, 0);
        tick();
        tick();
        check("t5_valid_rst2", d_vld, 0);
        rst_n = 1'b1;
        #1;
        check("t5_ready_rel", a_rdy, 1);
        tick();
        tick();
        tick();
        check("t5_no_data", d_vld, 0);
        req_accept(30'h7, 32'h77);
        wait_empty("t5_drain");

        // Write during WAIT: earlier edge is seen, same edge is not
        req_accept(30'h8, 32'h200);
        wr(10'd8, 32'h200);
        wait_empty("t6_new");
        req_accept(30'hA, 32'hA);
        tick();
        wr(10'd10, 32'hB);
        wait_empty("t6_old");
        req_accept(30'hA, 32'hB);
        wait_empty("t6_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
